// File: rtl/sar_pkg.sv
// Shared definitions for the SAR ADC readout path.
//   NBITS_DEF : default conversion width of the SAR logic
//   state_t   : sequencer states (sIdle, sBurst, sStop)
//   acc_width : width of the burst accumulator, wide enough that
//               2^navg_log2 full-scale codes can never overflow it
package sar_pkg;

  localparam int NBITS_DEF = 5;

  typedef enum logic [1:0] {
    sIdle  = 2'd0,
    sBurst = 2'd1,
    sStop  = 2'd2
  } state_t;

  function automatic int acc_width(input int nbits, input int navg_log2);
    return nbits + navg_log2;
  endfunction

endpackage

// File: rtl/sar_result_fifo.sv
// Synchronous FIFO holding averaged conversion codes.
//   CLK, RSTN        : clock, asynchronous active-low reset (control only)
//   push, push_data  : write request and data; ignored when full
//   pop              : read request; ignored when empty
//   head_data        : entry at the head, forced to zero while empty
//   count/full/empty : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module sar_result_fifo #(
  parameter int DATA_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  always_comb begin
    full      = (count == DEPTH_C);
    empty     = (count == '0);
    do_push   = push && !full;
    do_pop    = pop && !empty;
    // Zero while empty keeps the output defined without resetting storage.
    head_data = empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sar_readout_seq.sv
// Conversion sequencer and result buffer for the SAR ADC.
// Runs bursts of 2^NAVG_LOG2 conversions, averages them, checks every
// code for bits decided twice or never, and queues averages for readout.
//   CLK, RSTN          : clock shared with SAR logic, async active-low reset
//   EN                 : bursts run back-to-back while high
//   CLR_ERR            : synchronous clear of ERR (a new error wins)
//   GO                 : start request to the SAR logic
//   VALID, RESULTP/N   : done strobe and decided-1 / decided-0 bit vectors
//   OUT_DATA/VALID/READY : averaged-code stream with valid/ready handshake
//   ERR                : sticky code-consistency error
//   BUSY               : a burst (or abort wait) is in progress
module sar_readout_seq
  import sar_pkg::*;
#(
  parameter int NBITS      = NBITS_DEF,
  parameter int NAVG_LOG2  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             EN,
  input  logic             CLR_ERR,
  output logic             GO,
  input  logic             VALID,
  input  logic [NBITS-1:0] RESULTP,
  input  logic [NBITS-1:0] RESULTN,
  output logic [NBITS-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             ERR,
  output logic             BUSY
);

  localparam int ACC_W = acc_width(NBITS, NAVG_LOG2);
  localparam int CNT_W = (NAVG_LOG2 > 0) ? NAVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << NAVG_LOG2) - 1);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FCW-1:0] DEPTH_C = FCW'(FIFO_DEPTH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic             inflight;
  logic             last_vld;
  logic             push;
  logic             code_err;
  logic [FCW-1:0]   fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  // Truncating division of the burst sum by the burst length.
  function automatic logic [NBITS-1:0] avg_trunc(input logic [ACC_W-1:0] s);
    return NBITS'(s >> NAVG_LOG2);
  endfunction

  // Every bit must be decided exactly once: in P or N, never both.
  function automatic logic code_bad(input logic [NBITS-1:0] p,
                                    input logic [NBITS-1:0] n);
    return ((p ^ n) != '1) || ((p & n) != '0);
  endfunction

  always_comb begin
    acc_sum  = acc + ACC_W'(RESULTP);
    last_vld = VALID && (cnt == CNT_LAST);
    // Dropping GO on the last VALID parks the SAR logic in its wait state.
    GO       = (state == sBurst) && EN && !last_vld;
    push     = (state == sBurst) && EN && last_vld && !fifo_full;
    code_err = (state == sBurst) && VALID && code_bad(RESULTP, RESULTN);
    BUSY     = (state != sIdle);
  end

  // Control: state machine, conversion counter, in-flight tracking, ERR.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= sIdle;
      cnt      <= '0;
      inflight <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      // A conversion is running once GO was sampled, until its VALID.
      inflight <= GO || (inflight && !VALID);

      if (code_err)     ERR <= 1'b1;
      else if (CLR_ERR) ERR <= 1'b0;

      case (state)
        sIdle: begin
          if (EN && (fifo_count < DEPTH_C)) begin
            state <= sBurst;
            cnt   <= '0;
          end
        end
        sBurst: begin
          if (!EN) begin
            // Wait out a running conversion; if it finishes this very
            // cycle (or none was started) there is nothing to wait for.
            state <= (inflight && !VALID) ? sStop : sIdle;
          end else if (VALID) begin
            cnt <= cnt + CNT_W'(1);
            if (last_vld) state <= sIdle;
          end
        end
        sStop: begin
          if (VALID) state <= sIdle;
        end
        default: state <= sIdle;
      endcase
    end
  end

  // Datapath: accumulator is cleared every idle cycle, so no reset needed.
  always_ff @(posedge CLK) begin
    if (state == sIdle)                acc <= '0;
    else if (state == sBurst && VALID) acc <= acc_sum;
  end

  sar_result_fifo #(
    .DATA_W (NBITS),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .push      (push),
    .push_data (avg_trunc(acc_sum)),
    .pop       (OUT_READY),
    .head_data (OUT_DATA),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign OUT_VALID = !fifo_empty;

endmodule

// File: tb/tb_sar_readout_seq.sv
module tb_sar_readout_seq;

  localparam int NB    = 5;
  localparam int NAVG  = 2;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;

  logic          CLK = 1'b0;
  logic          RSTN, EN, CLR_ERR, GO, VALID, OUT_VALID, OUT_READY, ERR, BUSY;
  logic [NB-1:0] RESULTP, RESULTN, OUT_DATA;

  int n_chk = 0;
  int n_err = 0;
  logic [2*NB-1:0] code_q[$];
  int exp_q[$];
  bit conv;
  int timer;
  int nvalid = 0;

  sar_readout_seq #(.NBITS(NB), .NAVG_LOG2(NAVG), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RSTN(RSTN), .EN(EN), .CLR_ERR(CLR_ERR), .GO(GO),
    .VALID(VALID), .RESULTP(RESULTP), .RESULTN(RESULTN),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .ERR(ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_code(input logic [NB-1:0] p, input logic [NB-1:0] n);
    code_q.push_back({p, n});
  endtask

  task automatic push_burst(input int v, input bit expect_out);
    logic [NB-1:0] p;
    p = NB'(v);
    repeat (4) push_code(p, ~p);
    if (expect_out) exp_q.push_back(v);
  endtask

  // Returns mid-cycle (+3 after negedge) in the cycle of the n-th VALID.
  task automatic wait_valids(input int n, input string tag);
    int c = 0;
    int cyc = 0;
    while (c < n && cyc < 200) begin
      @(negedge CLK); #3;
      cyc++;
      if (VALID) c++;
    end
    if (c < n) check(tag, c, n);
  endtask

  // SAR logic model: samples GO when waiting or done, VALID LAT cycles later.
  initial begin
    logic [2*NB-1:0] cw;
    VALID = 1'b0; RESULTP = '0; RESULTN = '1; conv = 1'b0; timer = 0;
    forever begin
      @(negedge CLK);
      VALID = 1'b0;
      if (conv) begin
        timer--;
        if (timer == 0) begin
          if (code_q.size() > 0) cw = code_q.pop_front();
          else cw = {{NB{1'b0}}, {NB{1'b1}}};
          RESULTP = cw[2*NB-1:NB];
          RESULTN = cw[NB-1:0];
          VALID = 1'b1;
          conv = 1'b0;
          nvalid++;
        end
      end
      #1;
      if (!conv && GO) begin
        conv = 1'b1;
        timer = LAT;
      end
    end
  end

  // Scoreboard: every accepted output entry is compared to the queue head.
  initial begin
    int e;
    forever begin
      @(negedge CLK); #4;
      if (RSTN && OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check("sb_data", OUT_DATA, e);
        end
      end
    end
  end

  initial begin
    int n0;
    int pops;
    RSTN = 1'b0; EN = 1'b0; CLR_ERR = 1'b0; OUT_READY = 1'b1;
    repeat (2) @(negedge CLK);
    #3;
    check("rst_go", GO, 0);
    check("rst_err", ERR, 0);
    check("rst_busy", BUSY, 0);
    check("rst_ovalid", OUT_VALID, 0);
    check("rst_odata", OUT_DATA, 0);
    @(negedge CLK); RSTN = 1'b1;

    // Averaging: (10+11+12+13)/4 = 11
    for (int v = 10; v < 14; v++) push_code(NB'(v), ~NB'(v));
    exp_q.push_back(11);
    @(negedge CLK); EN = 1'b1;
    wait_valids(4, "t1_timeout");
    check("t1_go_last", GO, 0);
    check("t1_err", ERR, 0);
    @(negedge CLK); EN = 1'b0;
    #3;
    check("t1_latency", OUT_VALID, 1);
    check("t1_data", OUT_DATA, 11);
    repeat (3) @(negedge CLK);

    // Consistency error: 0A/04 leaves bit 0 undecided, still averages to 10
    push_code(5'h0A, 5'h04);
    repeat (3) push_code(5'h0A, 5'h15);
    exp_q.push_back(10);
    @(negedge CLK); EN = 1'b1;
    wait_valids(1, "t2a_timeout");
    @(negedge CLK); #3;
    check("t2_err_set", ERR, 1);
    wait_valids(3, "t2b_timeout");
    @(negedge CLK); EN = 1'b0;
    repeat (5) @(negedge CLK);
    #3;
    check("t2_err_sticky", ERR, 1);
    @(negedge CLK); CLR_ERR = 1'b1;
    @(negedge CLK); CLR_ERR = 1'b0;
    #3;
    check("t2_err_clr", ERR, 0);
    // CLR_ERR held high while a bad code arrives: set must win
    push_code(5'h0A, 5'h15);
    push_code(5'h0A, 5'h04);
    push_code(5'h0A, 5'h15);
    push_code(5'h0A, 5'h15);
    exp_q.push_back(10);
    @(negedge CLK); CLR_ERR = 1'b1; EN = 1'b1;
    wait_valids(2, "t2c_timeout");
    @(negedge CLK); #3;
    check("t2_set_wins", ERR, 1);
    wait_valids(2, "t2d_timeout");
    @(negedge CLK); EN = 1'b0;
    @(negedge CLK); CLR_ERR = 1'b0;
    #3;
    check("t2_err_final", ERR, 0);
    repeat (3) @(negedge CLK);

    // Abort after the 2nd VALID; 3rd in-flight VALID is discarded
    push_burst(7, 1'b0);
    @(negedge CLK); EN = 1'b1;
    wait_valids(2, "t4a_timeout");
    @(negedge CLK); EN = 1'b0;
    #3;
    check("t4_go", GO, 0);
    @(negedge CLK); #3;
    check("t4_stop_busy", BUSY, 1);
    check("t4_stop_go", GO, 0);
    wait_valids(1, "t4b_timeout");
    @(negedge CLK); #3;
    check("t4_idle", BUSY, 0);
    check("t4_nopush", OUT_VALID, 0);
    code_q.delete();
    repeat (3) @(negedge CLK);

    // Asynchronous reset mid-burst, then a stray VALID
    push_burst(9, 1'b0);
    push_burst(9, 1'b0);
    @(negedge CLK); OUT_READY = 1'b0; EN = 1'b1;
    wait_valids(5, "t5a_timeout");
    check("t5_pre_ovalid", OUT_VALID, 1);
    check("t5_pre_go", GO, 1);
    RSTN = 1'b0;
    #1;
    check("t5_go", GO, 0);
    check("t5_busy", BUSY, 0);
    check("t5_ovalid", OUT_VALID, 0);
    @(negedge CLK); EN = 1'b0; RSTN = 1'b1;
    wait_valids(1, "t5b_timeout");
    @(negedge CLK); #3;
    check("t5_stray_busy", BUSY, 0);
    check("t5_stray_ovalid", OUT_VALID, 0);
    code_q.delete();
    repeat (3) @(negedge CLK);

    // Backpressure: exactly 4 bursts fill the FIFO, then one pop frees a slot
    @(negedge CLK); OUT_READY = 1'b0;
    for (int k = 0; k < 5; k++) push_burst(3 + k, 1'b1);
    n0 = nvalid;
    EN = 1'b1;
    repeat (100) @(negedge CLK);
    #3;
    check("t3_conv", nvalid - n0, 16);
    check("t3_busy", BUSY, 0);
    check("t3_go", GO, 0);
    check("t3_head", OUT_DATA, 3);
    @(negedge CLK); OUT_READY = 1'b1;
    @(negedge CLK); OUT_READY = 1'b0;
    repeat (2) @(negedge CLK);
    #3;
    check("t3_resume", BUSY, 1);
    wait_valids(4, "t3_timeout");
    @(negedge CLK); EN = 1'b0; OUT_READY = 1'b1;
    repeat (10) @(negedge CLK);
    #3;
    check("t3_drained", OUT_VALID, 0);

    // Push and pop in the same cycle with two entries held
    @(negedge CLK); OUT_READY = 1'b0;
    push_burst(20, 1'b1);
    push_burst(21, 1'b1);
    push_burst(22, 1'b1);
    EN = 1'b1;
    wait_valids(12, "t6_timeout");
    OUT_READY = 1'b1;
    @(negedge CLK); OUT_READY = 1'b0; EN = 1'b0;
    #3;
    check("t6_ovalid", OUT_VALID, 1);
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK); #3;
      if (OUT_VALID) begin
        OUT_READY = 1'b1;
        pops++;
        @(negedge CLK); OUT_READY = 1'b0;
      end
    end
    check("t6_count", pops, 2);

    repeat (3) @(negedge CLK);
    check("sb_left", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sar_readout_seq.md
# sar_readout_seq

Conversion sequencer and result buffer for the SAR ADC.
- Drives the `GO` input of the SAR logic and captures each finished code on its `VALID` strobe.
- Averages bursts of 2^`NAVG_LOG2` conversions and checks that every bit was decided exactly once.
- Pushes averaged codes into a small FIFO that the downstream digital side reads with a valid/ready handshake.
- Sits between the SAR logic and the register or stream interface of the ADC macro.

## Interface
- `NBITS`, 5: conversion width; must match the SAR logic.
- `NAVG_LOG2`, 2: log2 of conversions per averaged sample; 0 means no averaging.
- `FIFO_DEPTH`, 4: output FIFO entries; a power of two, at least 2.

- `CLK`  in  1  single clock, shared with the SAR logic.
- `RSTN`  in  1  reset, asynchronous, active-low.
- `EN`  in  1  level; while high, bursts run back-to-back.
- `CLR_ERR`  in  1  synchronous clear of `ERR`.
- `GO`  out  1  to SAR logic `GO`.
- `VALID`  in  1  from SAR logic; one-cycle done strobe.
- `RESULTP`  in  `NBITS`  from SAR logic; bits decided as 1.
- `RESULTN`  in  `NBITS`  from SAR logic; bits decided as 0.
- `OUT_DATA`  out  `NBITS`  averaged code at the FIFO head.
- `OUT_VALID`  out  1  FIFO not empty.
- `OUT_READY`  in  1  consumer accepts the head entry.
- `ERR`  out  1  sticky code-consistency error.
- `BUSY`  out  1  a burst is in progress.

## Operation
- **States:** `sIdle`, `sBurst`, `sStop`.
- **`sIdle`:**
  - Enter `sBurst` when `EN`=1 and the FIFO count is less than `FIFO_DEPTH`.
  - On entry, clear the accumulator and the conversion counter `cnt`.
  - Because only one burst is in flight, a push always finds space: no overrun case exists.
- **`GO` in `sBurst`:** `GO` = `EN` & !(`VALID` & `cnt` == 2^`NAVG_LOG2`-1).
  - This deasserts `GO` in the `VALID` cycle of the last conversion, so the SAR logic returns to its wait state instead of starting again.
- **`GO` elsewhere:** `GO`=0 in `sIdle` and `sStop`. `GO` is combinational from registered state and inputs.
- **On each `VALID` in `sBurst`:**
  - acc <= acc + `RESULTP`.
  - `cnt`++.
  - If (`RESULTP` ^ `RESULTN`) != all-ones, or (`RESULTP` & `RESULTN`) != 0, set `ERR`. The code is still accumulated.
- **Last `VALID` of a burst:**
  - Push (acc + `RESULTP`) >> `NAVG_LOG2` into the FIFO. This is truncating division; the accumulator is `NBITS`+`NAVG_LOG2` wide and cannot overflow.
  - Return to `sIdle`. If `EN` is still 1 and space exists, the next burst starts on the following cycle.
- **`EN` falls during `sBurst`:**
  - Go to `sStop` with `GO`=0.
  - Wait for the in-flight `VALID`, discard the partial burst, and return to `sIdle`; nothing is pushed.
  - If `EN` falls in the same cycle as `VALID`, that conversion is discarded.
- **`VALID` seen in `sIdle`** (for example, after this block is reset while the SAR logic is running): ignored.
- **`ERR`:**
  - Set has priority over `CLR_ERR` in the same cycle.
  - Cleared only by `CLR_ERR` or reset.
- **FIFO:**
  - `OUT_DATA` and `OUT_VALID` come from the head entry.
  - A pop occurs when `OUT_VALID` & `OUT_READY`.
  - Push and pop in the same cycle leaves the count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - `OUT_DATA` is held stable while `OUT_VALID`=1 and `OUT_READY`=0.

## Timing
- **Reset values:** `GO`=0, `ERR`=0, `BUSY`=0, `OUT_VALID`=0, `OUT_DATA`=0. Reset is asynchronous, so `GO` drops immediately when `RSTN` goes low.
- **SAR logic timing:**
  - `GO` is sampled while the SAR logic waits or is done.
  - `VALID` is high for exactly one cycle, with `RESULTP`/`RESULTN` final during that cycle.
  - Back-to-back conversions inside a burst have no idle cycle.
- **Latency:** the last `VALID` at edge n gives `OUT_VALID`=1 after edge n+1, when the FIFO was empty.
- **Burst gap:** one `sIdle` cycle between bursts, with `GO`=0.
- **`BUSY`:** equals (state != `sIdle`).

## Structure
- Shared package `sar_pkg`:
  - `NBITS` default.
  - State encoding localparams `sIdle`, `sBurst`, `sStop`.
  - Accumulator width function `NBITS`+`NAVG_LOG2`.
- One sub-module `sar_result_fifo`: a synchronous FIFO parameterised by width and depth. It has push/pop, count, full and empty outputs, and no bypass path.
- The top level holds the state machine, `cnt`, the accumulator and the `ERR` logic.

## Test plan
Default parameters unless noted.
1. **Averaging.** `EN`=1; model returns `RESULTP` 10, 11, 12, 13 (with `RESULTN` = ~`RESULTP`) → `OUT_DATA`=11 one cycle after the 4th `VALID`. `GO` is low in that `VALID` cycle, and `ERR`=0.
2. **Consistency error.** `NAVG_LOG2`=0; `RESULTP`=5'h0A, `RESULTN`=5'h04 → `ERR`=1 and `OUT_DATA`=10. `ERR` stays 1 until `CLR_ERR`; with `CLR_ERR` and a new error in the same cycle, `ERR` stays 1.
3. **Backpressure.** `OUT_READY`=0 with `EN`=1 → exactly 4 entries are pushed, then the block stays in `sIdle` with `GO`=0. Raising `OUT_READY` for 1 cycle → a new burst starts, and entries drain in order.
4. **Abort.** `EN` falls after the 2nd `VALID` of a burst → `GO`=0 immediately; the 3rd in-flight `VALID` is discarded, nothing is pushed, and the block returns to `sIdle`.
5. **Asynchronous reset mid-burst.** `RSTN` is asserted between edges → `GO`, `BUSY` and `OUT_VALID` drop at once. After release, a stray `VALID` is ignored and the FIFO is empty.
6. **Simultaneous push and pop.** FIFO holds 2 entries; a push and a pop land in the same cycle → count stays 2 and order is preserved across pointer wrap.
